cfg_frame_ctrl: RTL

//  Parametrised byte-stream configuration controller. Sits after the UART RX and parses

---
 rtl/cfg_frame_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cfg_frame_ctrl.sv
// Byte-stream config parser: {addr, data[DATA_BYTES]} frames into a register bank plus a
// delayed config_en start pulse. Define CFG_CHECKSUM_EN for a trailing checksum byte.
module cfg_frame_ctrl #(
    parameter int DATA_BYTES = 1,
    parameter int NUM_REGS   = 4,
    parameter int TIMEOUT    = 1000,
    parameter int START_DLY  = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       din,
    input  logic                             din_vld,
    output logic [NUM_REGS*8*DATA_BYTES-1:0] reg_bus,
    output logic [NUM_REGS-1:0]              wr_pulse,
    output logic                             config_en,
    output logic                             frame_err
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int TCW = $clog2(TIMEOUT);
    localparam int DCW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

    typedef enum logic [1:0] {
        S_ADDR,
`ifdef CFG_CHECKSUM_EN
        S_CSUM,
`endif
        S_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      addr_q;
    logic [DW-1:0]   data_q, data_next, commit_data;
    logic [BCW-1:0]  byte_cnt_q;
    logic [TCW-1:0]  idle_q;
    logic [DCW-1:0]  dly_cnt_q;
    logic            dly_arm_q;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic            frame_done, timeout, start_cmd, csum_bad;
`ifdef CFG_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    assign data_next = DW'({data_q, din});
    assign timeout   = (state_q != S_ADDR) && !din_vld && (idle_q == TCW'(TIMEOUT - 1));
    assign start_cmd = frame_done && (addr_q == 8'h01) && (commit_data == DW'(1));

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        csum_bad   = 1'b0;
`ifdef CFG_CHECKSUM_EN
        commit_data = data_q;
`else
        commit_data = data_next;
`endif
        unique case (state_q)
            S_ADDR: if (din_vld) state_d = S_DATA;
            S_DATA: begin
                if (din_vld) begin
                    if (byte_cnt_q == BCW'(DATA_BYTES - 1)) begin
`ifdef CFG_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d    = S_ADDR;
                        frame_done = 1'b1;
`endif
                    end
                end else if (timeout) begin
                    state_d = S_ADDR;
                end
            end
`ifdef CFG_CHECKSUM_EN
            S_CSUM: begin
                if (din_vld) begin
                    state_d    = S_ADDR;
                    frame_done = (din == csum_q);
                    csum_bad   = (din != csum_q);
                end else if (timeout) begin
                    state_d = S_ADDR;
                end
            end
`endif
            default: state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ADDR;
            addr_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            idle_q     <= '0;
`ifdef CFG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (din_vld || state_q == S_ADDR || timeout)
                idle_q <= '0;
            else
                idle_q <= idle_q + TCW'(1);
            if (din_vld && state_q == S_ADDR) begin
                addr_q     <= din;
                byte_cnt_q <= '0;
`ifdef CFG_CHECKSUM_EN
                csum_q     <= din;
`endif
            end
            if (din_vld && state_q == S_DATA) begin
                data_q     <= data_next;
                byte_cnt_q <= byte_cnt_q + BCW'(1);
`ifdef CFG_CHECKSUM_EN
                csum_q     <= csum_q + din;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_pulse  <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse  <= '0;
            frame_err <= timeout || csum_bad;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (frame_done && addr_q == 8'(2 + i)) begin
                    regs_q[i]   <= commit_data;
                    wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    // A fresh start command always reloads, so a pending pulse is pushed out rather than doubled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt_q <= '0;
            dly_arm_q <= 1'b0;
            config_en <= 1'b0;
        end else begin
            config_en <= 1'b0;
            if (start_cmd) begin
                if (START_DLY == 1) begin
                    config_en <= 1'b1;
                    dly_arm_q <= 1'b0;
                end else begin
                    dly_cnt_q <= DCW'(START_DLY - 1);
                    dly_arm_q <= 1'b1;
                end
            end else if (dly_arm_q) begin
                if (dly_cnt_q == DCW'(1)) begin
                    config_en <= 1'b1;
                    dly_arm_q <= 1'b0;
                end
                dly_cnt_q <= dly_cnt_q - DCW'(1);
            end
        end
    end

    always_comb begin
        reg_bus = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) reg_bus[i*DW +: DW] = regs_q[i];
    end

endmodule
